// File: rtl/pgm_ddram_resp.sv
`default_nettype none
// ============================================================================
//  Module   : pgm_ddram_resp
//  Purpose  : On-chip responder for a DDRAM-style 64-bit word port. Writes
//             complete in one cycle with per-byte enables. Reads return data
//             a fixed RD_LAT cycles after accept, marked by a one-cycle
//             ddram_dout_ready pulse. Requests that cannot be serviced are
//             counted, and any access beyond the backed range sets a sticky
//             error flag.
//  Ports    : fixed_50m_clk     - clock (rising edge)
//             reset             - synchronous, active-high reset
//             ddram_rd/we       - read / write request levels
//             ddram_addr[28:0]  - 64-bit word address
//             ddram_din[63:0]   - write data
//             ddram_be[7:0]     - byte enables
//             ddram_busy        - read in flight, requests not accepted
//             ddram_dout[63:0]  - last completed read data
//             ddram_dout_ready  - one-cycle valid pulse for ddram_dout
//             drop_cnt[7:0]     - saturating count of refused requests
//             oob_err           - sticky out-of-range access flag
//  Revision : 1.0  initial release
// ============================================================================
module pgm_ddram_resp #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 4
) (
  input  logic        fixed_50m_clk,
  input  logic        reset,
  input  logic        ddram_rd,
  input  logic        ddram_we,
  input  logic [28:0] ddram_addr,
  input  logic [63:0] ddram_din,
  input  logic [7:0]  ddram_be,
  output logic        ddram_busy,
  output logic [63:0] ddram_dout,
  output logic        ddram_dout_ready,
  output logic [7:0]  drop_cnt,
  output logic        oob_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_DONE = 2'd2
  } state_t;

  localparam logic [3:0] c_cnt_load = 4'(RD_LAT - 1);
  localparam int         c_depth    = 1 << ADDR_W;

  state_t              r_state;
  state_t              w_state_next;
  logic [3:0]          r_cnt;
  logic [ADDR_W-1:0]   r_addr;
  logic                r_oob;
  logic [63:0]         r_rdata;
  logic [63:0]         r_mem [0:c_depth-1];

  logic                w_oob;
  logic                w_rd_accept;
  logic                w_wr_accept;
  logic                w_drop;
  logic [ADDR_W-1:0]   w_mem_addr;

  // Address bits above the backed range flag an out-of-bounds access.
  generate
    if (ADDR_W < 29) begin : g_oob_chk
      assign w_oob = |ddram_addr[28:ADDR_W];
    end else begin : g_no_oob
      assign w_oob = 1'b0;
    end
  endgenerate

  always_comb begin
    w_state_next     = r_state;
    ddram_busy       = 1'b0;
    ddram_dout_ready = 1'b0;
    w_rd_accept      = 1'b0;
    w_wr_accept      = 1'b0;
    w_drop           = 1'b0;
    case (r_state)
      IDLE: begin
        // A simultaneous rd+we is serviced as a write only; the read is dropped.
        if (ddram_we) begin
          w_wr_accept = 1'b1;
          w_drop      = ddram_rd;
        end else if (ddram_rd) begin
          w_rd_accept  = 1'b1;
          w_state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        ddram_busy = 1'b1;
        w_drop     = ddram_rd | ddram_we;
        if (r_cnt == 4'd1) begin
          w_state_next = RD_DONE;
        end
      end
      RD_DONE: begin
        ddram_busy       = 1'b1;
        ddram_dout_ready = 1'b1;
        w_drop           = ddram_rd | ddram_we;
        w_state_next     = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Single memory port: the request address while idle, the latched read
  // address while a read is in flight (no writes are accepted then).
  assign w_mem_addr = ddram_busy ? r_addr : ddram_addr[ADDR_W-1:0];

  always_ff @(posedge fixed_50m_clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_addr   <= '0;
      r_oob    <= 1'b0;
      ddram_dout <= 64'd0;
      drop_cnt <= 8'd0;
      oob_err  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_rd_accept) begin
        r_cnt  <= c_cnt_load;
        r_addr <= ddram_addr[ADDR_W-1:0];
        r_oob  <= w_oob;
      end else if (r_state == RD_WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      // Output register is loaded only on the edge that enters RD_DONE.
      if (r_state == RD_WAIT && w_state_next == RD_DONE) begin
        ddram_dout <= r_oob ? 64'd0 : r_rdata;
      end
      if (w_drop && drop_cnt != 8'hFF) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
      if ((w_rd_accept || w_wr_accept) && w_oob) begin
        oob_err <= 1'b1;
      end
    end
  end

  // Block RAM: byte-enable write, registered read. Contents survive reset.
  always_ff @(posedge fixed_50m_clk) begin
    if (!reset && w_wr_accept && !w_oob) begin
      for (int k = 0; k < 8; k++) begin
        if (ddram_be[k]) begin
          r_mem[w_mem_addr][8*k +: 8] <= ddram_din[8*k +: 8];
        end
      end
    end
    r_rdata <= r_mem[w_mem_addr];
  end

endmodule
`default_nettype wire

// File: tb/tb_pgm_ddram_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pgm_ddram_resp
//  Purpose  : Directed, self-checking bench for pgm_ddram_resp. Expected read
//             data and due cycles are queued when a read is driven and popped
//             when the ready pulse appears.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pgm_ddram_resp;

  localparam int ADDR_W = 16;
  localparam int RD_LAT = 4;

  logic        fixed_50m_clk = 1'b0;
  logic        reset;
  logic        ddram_rd;
  logic        ddram_we;
  logic [28:0] ddram_addr;
  logic [63:0] ddram_din;
  logic [7:0]  ddram_be;
  logic        ddram_busy;
  logic [63:0] ddram_dout;
  logic        ddram_dout_ready;
  logic [7:0]  drop_cnt;
  logic        oob_err;

  pgm_ddram_resp #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
    .fixed_50m_clk    (fixed_50m_clk),
    .reset            (reset),
    .ddram_rd         (ddram_rd),
    .ddram_we         (ddram_we),
    .ddram_addr       (ddram_addr),
    .ddram_din        (ddram_din),
    .ddram_be         (ddram_be),
    .ddram_busy       (ddram_busy),
    .ddram_dout       (ddram_dout),
    .ddram_dout_ready (ddram_dout_ready),
    .drop_cnt         (drop_cnt),
    .oob_err          (oob_err)
  );

  always #5 fixed_50m_clk = ~fixed_50m_clk;

  typedef struct {
    logic [63:0] data;
    int          due;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  logic        after_pulse = 1'b0;
  logic [63:0] model [logic [28:0]];

  always @(posedge fixed_50m_clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ready-pulse monitor: pops the scoreboard and checks data, timing and busy.
  always @(negedge fixed_50m_clk) begin
    if (ddram_dout_ready === 1'b1) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 64'(ddram_dout_ready), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("rd_data", ddram_dout, e.data);
        check("rd_due_cycle", 64'(cyc), 64'(e.due));
        check("busy_at_pulse", 64'(ddram_busy), 64'd1);
        after_pulse = 1'b1;
      end
    end else if (after_pulse) begin
      check("busy_after_pulse", 64'(ddram_busy), 64'd0);
      after_pulse = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge fixed_50m_clk);
    #1;
  endtask

  function automatic logic is_oob(input logic [28:0] a);
    return |a[28:ADDR_W];
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] din,
                                        input logic [7:0] be);
    logic [63:0] r;
    r = old;
    for (int k = 0; k < 8; k++) if (be[k]) r[8*k +: 8] = din[8*k +: 8];
    return r;
  endfunction

  task automatic wr(input logic [28:0] a, input logic [63:0] d, input logic [7:0] be);
    logic [63:0] old;
    ddram_we = 1'b1; ddram_addr = a; ddram_din = d; ddram_be = be;
    tick(1);
    ddram_we = 1'b0;
    if (!is_oob(a)) begin
      old = model.exists(a) ? model[a] : 64'd0;
      model[a] = merge(old, d, be);
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(negedge fixed_50m_clk);
    check(tag, 64'(sb.size()), 64'd0);
    tick(2);
  endtask

  task automatic rd(input logic [28:0] a);
    exp_t e;
    ddram_rd = 1'b1; ddram_addr = a;
    e.data = is_oob(a) ? 64'd0 : model[a];
    e.due  = cyc + RD_LAT;
    sb.push_back(e);
    tick(1);
    ddram_rd = 1'b0;
    drain("rd_drain");
  endtask

  initial begin
    exp_t e;
    int   e0;
    reset = 1'b1; ddram_rd = 1'b0; ddram_we = 1'b0;
    ddram_addr = '0; ddram_din = '0; ddram_be = '0;
    tick(3);
    check("rst_busy", 64'(ddram_busy), 64'd0);
    check("rst_ready", 64'(ddram_dout_ready), 64'd0);
    check("rst_dout", ddram_dout, 64'd0);
    check("rst_drop", 64'(drop_cnt), 64'd0);
    check("rst_oob", 64'(oob_err), 64'd0);
    reset = 1'b0;
    tick(1);

    // Full write then read-back.
    wr(29'h0, 64'hCAFE_F00D_0BAD_BEEF, 8'hFF);
    wr(29'h10, 64'h1122_3344_5566_7788, 8'hFF);
    rd(29'h10);

    // Partial byte-enable write.
    wr(29'h10, 64'hAAAA_AAAA_AAAA_AAAA, 8'h03);
    check("merge_model", model[29'h10], 64'h1122_3344_5566_AAAA);
    rd(29'h10);

    // Zero byte-enable write: no change, no drop.
    wr(29'h10, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
    rd(29'h10);
    check("be0_drop", 64'(drop_cnt), 64'd0);

    // Held read for 20 cycles: four reads every RD_LAT+1 cycles.
    ddram_rd = 1'b1; ddram_addr = 29'h10;
    e0 = cyc;
    for (int k = 0; k < 4; k++) begin
      e.data = 64'h1122_3344_5566_AAAA;
      e.due  = e0 + RD_LAT + k * (RD_LAT + 1);
      sb.push_back(e);
    end
    tick(20);
    ddram_rd = 1'b0;
    drain("hold_drain");
    check("hold_drop", 64'(drop_cnt), 64'd16);

    // Simultaneous rd+we: write only, one drop, no pulse.
    ddram_rd = 1'b1; ddram_we = 1'b1; ddram_addr = 29'h20;
    ddram_din = 64'h5; ddram_be = 8'hFF;
    tick(1);
    ddram_rd = 1'b0; ddram_we = 1'b0;
    model[29'h20] = 64'h5;
    tick(RD_LAT + 2);
    check("rdwe_busy", 64'(ddram_busy), 64'd0);
    check("rdwe_drop", 64'(drop_cnt), 64'd17);
    rd(29'h20);

    // Out-of-range read and write.
    check("oob_before", 64'(oob_err), 64'd0);
    rd(29'h0100_0000);
    check("oob_after_rd", 64'(oob_err), 64'd1);
    wr(29'h0100_0000, 64'hDEAD_DEAD_DEAD_DEAD, 8'hFF);
    rd(29'h0);

    // Reset two cycles after a read accept aborts it; requests during reset ignored.
    ddram_rd = 1'b1; ddram_addr = 29'h10;
    tick(1);
    ddram_rd = 1'b0;
    tick(1);
    reset = 1'b1; ddram_rd = 1'b1;
    tick(2);
    reset = 1'b0; ddram_rd = 1'b0;
    check("abort_busy", 64'(ddram_busy), 64'd0);
    check("abort_dout", ddram_dout, 64'd0);
    check("abort_drop", 64'(drop_cnt), 64'd0);
    check("abort_oob", 64'(oob_err), 64'd0);
    tick(RD_LAT + 2);
    rd(29'h10);
    check("post_rst_drop", 64'(drop_cnt), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pgm_ddram_resp.md
PGM_DDRAM_RESP -- requirements
Module: pgm_ddram_resp

Interface
REQ-001 Parameter ADDR_W, default 16; number of 64-bit word-address bits backed by on-chip memory (depth 2^ADDR_W words).
REQ-002 Parameter RD_LAT, default 4; cycles from read accept to the data-ready pulse; legal range 2..15.
REQ-003 fixed_50m_clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ddram_rd  in  1  read request level; sampled only while ddram_busy is low.
REQ-006 ddram_we  in  1  write request level; sampled only while ddram_busy is low.
REQ-007 ddram_addr  in  29  64-bit word address.
REQ-008 ddram_din  in  64  write data.
REQ-009 ddram_be  in  8  byte enables; bit k enables write of ddram_din[8k+7:8k].
REQ-010 ddram_busy  out  1  high while a read is in flight; requests presented while high are not accepted.
REQ-011 ddram_dout  out  64  read data; holds the last completed read value.
REQ-012 ddram_dout_ready  out  1  one-cycle pulse marking ddram_dout valid.
REQ-013 drop_cnt  out  8  saturating count of requests not accepted.
REQ-014 oob_err  out  1  sticky flag: an access addressed beyond the backed range.

Function
REQ-015 The block SHALL implement states IDLE, RD_WAIT and RD_DONE.
REQ-016 IDLE, ddram_rd=1, ddram_we=0: latch the address, load the latency counter with RD_LAT-1 and go to RD_WAIT; ddram_busy SHALL be high from the next cycle.
REQ-017 RD_WAIT: decrement the counter each cycle; at count 1, go to RD_DONE.
REQ-018 RD_DONE: ddram_dout_ready=1 for exactly this cycle, with ddram_dout valid and ddram_busy still high; return to IDLE on the next edge.
REQ-019 An accept at edge N SHALL produce ddram_dout_ready high in the cycle following edge N+RD_LAT-1, i.e., RD_LAT cycles after accept; ddram_busy SHALL drop in the cycle after the pulse.
REQ-020 A held ddram_rd SHALL be re-accepted only once ddram_busy is low again, giving back-to-back reads a period of RD_LAT+1 cycles.
REQ-021 IDLE, ddram_we=1: write the enabled bytes of ddram_din to word ddram_addr[ADDR_W-1:0] at that edge; the write does not assert ddram_busy, so writes are accepted every cycle.
REQ-022 IDLE, ddram_rd=1 and ddram_we=1 together: perform the write only, remain in IDLE, and increment drop_cnt once.
REQ-023 Any ddram_rd or ddram_we high while ddram_busy is high SHALL increment drop_cnt once per cycle and have no other effect.
REQ-024 drop_cnt SHALL saturate at 255.
REQ-025 Out-of-range address (any bit of ddram_addr[28:ADDR_W] set) on a write: memory is unchanged and oob_err is set.
REQ-026 Out-of-range address on a read: normal timing, ddram_dout=0, and oob_err is set.
REQ-027 A write with ddram_be=0 SHALL be accepted with no memory change and no drop count.
REQ-028 ddram_dout SHALL change only in the RD_DONE cycle.
REQ-029 The memory SHALL be a single-port block RAM read-modify-free (byte-enable write).
REQ-030 The read address SHALL be registered at accept, and the read SHALL complete within the RD_LAT window.

Reset
REQ-031 While reset is high, on each edge: state=IDLE, ddram_busy=0, ddram_dout_ready=0, ddram_dout=0, drop_cnt=0, oob_err=0.
REQ-032 Reset asserted mid-read SHALL abort the read with no ddram_dout_ready pulse.
REQ-033 Requests presented while reset is high SHALL be ignored and not counted.
REQ-034 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-035 Write addr 0x10, din 0x1122334455667788, be 0xFF; then read 0x10 -> ddram_dout_ready pulses 4 cycles after accept with 0x1122334455667788; busy low the following cycle.
REQ-036 Over word 0x10 above, write din 0xAAAA...AA with be 0x03, then read -> 0x112233445566AAAA.
REQ-037 Hold ddram_rd high for 20 cycles at addr 0x10 -> 4 pulses spaced 5 cycles apart; drop_cnt=16 (4 held cycles per read while busy).
REQ-038 rd=1 and we=1 together at addr 0x20 with din 0x5 -> write lands, no ready pulse, drop_cnt=1.
REQ-039 Read addr 0x0100_0000 -> ready pulse after 4 cycles with dout=0, oob_err=1; a write there leaves memory unchanged.
REQ-040 Assert reset 2 cycles after a read accept -> no ready pulse; busy=0, dout=0 and drop_cnt=0 after reset; memory still holds the earlier data.
